mux_serial_8a1: RTL and testbench
=================================

Name: mux_serial_8a1

Overview:
- Time-division serializer: captures one word of N_CANALES parallel channels and sends them one channel per clock on a single line.
- Drives a channel-index bus so a downstream 1-to-8 demultiplexer can route each symbol back to its output.
- Sits at the transmit end of the mux/demux link; its `control` output connects directly to the demux `control` select.

Parameters:
- N_CANALES, 8, number of channels per frame (≥2).
- SEL_W, 3, width of the channel index; must equal ceil(log2(N_CANALES)).
- ANCHO, 1, bits per channel symbol.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entradas  input  N_CANALES*ANCHO  parallel frame; channel i occupies bits [i*ANCHO +: ANCHO].
- datos_validos  input  1  frame on `entradas` is valid.
- datos_listo  output  1  block can accept a frame this cycle.
- pausa  input  1  stall request during transmission.
- salida  output  ANCHO  current serialized symbol.
- control  output  SEL_W  channel index of the symbol on `salida`.
- valido  output  1  `salida`/`control` carry a real symbol this cycle.
- inicio_trama  output  1  high with channel 0 of each frame.
- fin_trama  output  1  high with channel N_CANALES-1 of each frame.

Behaviour:
Reset:
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- On reset: estado=REPOSO, idx=0, shadow register=0, salida=0, control=0, valido=0, inicio_trama=0, fin_trama=0.
- Asserting reset mid-frame aborts the frame immediately; no partial resume after release.

States:
- REPOSO: idle, waiting for a frame.
- ENVIO: transmitting a frame.

datos_listo (combinational):
- 1 in REPOSO.
- 1 in ENVIO only when idx==N_CANALES-1 and pausa==0.
- 0 otherwise.

Acceptance and latency:
- A frame is accepted on a rising edge where datos_validos && datos_listo.
- At that edge: `entradas` is copied to the shadow register, salida=entradas[channel 0], control=0, idx=0, valido=1, inicio_trama=1, fin_trama=(N_CANALES==1 ? 1 : 0), estado=ENVIO.
- Latency is 1: channel 0 is visible in the cycle after acceptance.

ENVIO, pausa==0:
- At each edge, idx increments and salida=shadow[idx+1], control=idx+1, valido=1.
- inicio_trama=0; fin_trama=1 when the new idx == N_CANALES-1.

End of frame (edge where idx==N_CANALES-1, pausa==0):
- If a frame is accepted: reload as above. Back-to-back frames have no gap and inicio_trama follows fin_trama directly.
- Otherwise: estado=REPOSO, valido=0, inicio_trama=0, fin_trama=0, idx=0. salida/control hold their last values.

ENVIO, pausa==1:
- idx, shadow, salida and control hold.
- valido=0, inicio_trama=0, fin_trama=0 for that cycle.
- When pausa drops, the held symbol is re-presented with valido=1, then serialization continues.
- inicio_trama/fin_trama re-assert if the held symbol is channel 0 / N_CANALES-1.

Other rules:
- pausa in REPOSO has no effect; acceptance is still allowed.
- Changes to `entradas` after acceptance do not affect the frame in flight.
- datos_validos while datos_listo==0 is ignored; no capture, no error.
- idx never exceeds N_CANALES-1. No wrap-around except the reload to 0.
- Symbols per frame = N_CANALES exactly, regardless of pauses.

Decomposition:
- Shared package (`mux_demux_pkg`): N_CANALES_DEF=8, SEL_W_DEF=3, ANCHO_DEF=1, state enum {REPOSO, ENVIO}.
- Sub-module `contador_canal`: SEL_W-bit counter with enable, synchronous clear, async reset and terminal-count flag (idx==N_CANALES-1). Instantiated once.
- Frame FSM and output registers stay in `mux_serial_8a1`.

Test Plan:
- Reset then idle, datos_validos=0 → datos_listo=1, valido=0, salida=0, control=0, both frame flags 0 for 20 cycles.
- Single frame entradas=8'b1011_0010, pausa=0 → over 8 cycles after acceptance, salida = 0,1,0,0,1,1,0,1 with control 0..7; inicio_trama only at control=0, fin_trama only at control=7; then valido=0.
- Back-to-back: datos_validos held high with 8'hA5 then 8'h3C → 16 consecutive valido=1 cycles; control 7→0 with no gap; fin_trama then inicio_trama on adjacent cycles.
- Pause: frame 8'hFF, pausa=1 for 3 cycles while control=4 → control stays 4 with valido=0 for 3 cycles; total valid symbols still 8; fin_trama at control=7.
- Input change after capture: accept 8'h0F, drive entradas=8'hF0 next cycle → serialized bits still 1,1,1,1,0,0,0,0.
- Reset mid-frame: assert rst_n=0 at control=3 → outputs cleared asynchronously; after release, datos_listo=1 and the next accepted frame starts at control=0 with inicio_trama=1.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// Shared definitions for the serial mux/demux link.
// Default frame geometry and the transmit FSM states.
package mux_demux_pkg;

    localparam int N_CANALES_DEF = 8;
    localparam int SEL_W_DEF     = 3;
    localparam int ANCHO_DEF     = 1;

    typedef enum logic {
        REPOSO = 1'b0,
        ENVIO  = 1'b1
    } estado_e;

endpackage

// File: rtl/mux_serial_8a1_if.sv
// Frame-in / symbol-out bundle of the serializer.
// master = frame source and downstream sink, slave = serializer.
interface mux_serial_8a1_if
    import mux_demux_pkg::*;
#(
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int ANCHO     = ANCHO_DEF
);

    logic [N_CANALES*ANCHO-1:0] entradas;
    logic                       datos_validos;
    logic                       datos_listo;
    logic                       pausa;
    logic [ANCHO-1:0]           salida;
    logic [SEL_W-1:0]           control;
    logic                       valido;
    logic                       inicio_trama;
    logic                       fin_trama;

    modport master (
        output entradas,
        output datos_validos,
        output pausa,
        input  datos_listo,
        input  salida,
        input  control,
        input  valido,
        input  inicio_trama,
        input  fin_trama
    );

    modport slave (
        input  entradas,
        input  datos_validos,
        input  pausa,
        output datos_listo,
        output salida,
        output control,
        output valido,
        output inicio_trama,
        output fin_trama
    );

endinterface

// File: rtl/mux_serial_8a1_contador_canal.sv
// Channel index counter: clear wins over enable,
// tc flags the last channel of the frame.
module contador_canal
    import mux_demux_pkg::*;
#(
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int SEL_W     = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [SEL_W-1:0] q,
    output logic             tc
);

    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(N_CANALES - 1);

    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q  = cnt_q;
    assign tc = (cnt_q == ULTIMO);

endmodule

// File: rtl/mux_serial_8a1.sv
// Time-division serializer: one captured frame out,
// one channel per clock, with channel index for the demux.
module mux_serial_8a1
    import mux_demux_pkg::*;
#(
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int ANCHO     = ANCHO_DEF
) (
    input logic             clk,
    input logic             rst_n,
    mux_serial_8a1_if.slave bus
);

    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(N_CANALES - 1);

    estado_e                    estado_q, estado_d;
    logic [N_CANALES*ANCHO-1:0] shadow_q, shadow_d;
    logic [ANCHO-1:0]           salida_q, salida_d;
    logic [SEL_W-1:0]           control_q, control_d;
    logic                       valido_q, valido_d;
    logic                       inicio_q, inicio_d;
    logic                       fin_q, fin_d;
    logic                       pausado_q, pausado_d;

    logic [SEL_W-1:0] idx, idx_nx;
    logic             tc, en, clr;
    logic             enviando, avanza, listo, acepta;

    assign enviando = (estado_q == ENVIO);
    assign avanza   = enviando && !bus.pausa;
    assign listo    = !enviando || (tc && !bus.pausa);
    assign acepta   = bus.datos_validos && listo;
    assign idx_nx   = idx + 1'b1;

    // A symbol held by a pause is re-presented before the index moves on.
    assign en  = avanza && !tc && !pausado_q;
    assign clr = acepta || (avanza && tc && !pausado_q);

    contador_canal #(
        .N_CANALES (N_CANALES),
        .SEL_W     (SEL_W)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .q     (idx),
        .tc    (tc)
    );

    always_comb begin
        estado_d  = estado_q;
        shadow_d  = shadow_q;
        salida_d  = salida_q;
        control_d = control_q;
        valido_d  = valido_q;
        inicio_d  = inicio_q;
        fin_d     = fin_q;
        pausado_d = pausado_q;
        if (acepta) begin
            estado_d  = ENVIO;
            shadow_d  = bus.entradas;
            salida_d  = bus.entradas[ANCHO-1:0];
            control_d = '0;
            valido_d  = 1'b1;
            inicio_d  = 1'b1;
            fin_d     = (N_CANALES == 1);
            pausado_d = 1'b0;
        end else if (enviando && bus.pausa) begin
            valido_d  = 1'b0;
            inicio_d  = 1'b0;
            fin_d     = 1'b0;
            pausado_d = 1'b1;
        end else if (avanza && pausado_q) begin
            valido_d  = 1'b1;
            inicio_d  = (idx == '0);
            fin_d     = tc;
            pausado_d = 1'b0;
        end else if (avanza && !tc) begin
            salida_d  = shadow_q[int'(idx_nx)*ANCHO +: ANCHO];
            control_d = idx_nx;
            valido_d  = 1'b1;
            inicio_d  = 1'b0;
            fin_d     = (idx_nx == ULTIMO);
        end else if (avanza) begin
            estado_d  = REPOSO;
            valido_d  = 1'b0;
            inicio_d  = 1'b0;
            fin_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            shadow_q  <= '0;
            salida_q  <= '0;
            control_q <= '0;
            valido_q  <= 1'b0;
            inicio_q  <= 1'b0;
            fin_q     <= 1'b0;
            pausado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            shadow_q  <= shadow_d;
            salida_q  <= salida_d;
            control_q <= control_d;
            valido_q  <= valido_d;
            inicio_q  <= inicio_d;
            fin_q     <= fin_d;
            pausado_q <= pausado_d;
        end
    end

    assign bus.datos_listo  = listo;
    assign bus.salida       = salida_q;
    assign bus.control      = control_q;
    assign bus.valido       = valido_q;
    assign bus.inicio_trama = inicio_q;
    assign bus.fin_trama    = fin_q;

endmodule

// File: tb/tb_mux_serial_8a1.sv
// Directed-vector bench for the 8-channel serializer.
module tb_mux_serial_8a1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux_serial_8a1_if #(.N_CANALES(8), .SEL_W(3), .ANCHO(1)) bus ();

    mux_serial_8a1 #(.N_CANALES(8), .SEL_W(3), .ANCHO(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst_n             = 1'b0;
        bus.entradas      = '0;
        bus.datos_validos = 1'b0;
        bus.pausa         = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            obs = {bus.datos_listo, bus.valido, bus.salida, bus.control,
                   bus.inicio_trama, bus.fin_trama};
            checks++;
            if (obs !== 8'b1000_0000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=10000000",
                         c, obs);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] fr;
        logic [6:0] obs, exp;
        logic [7:0] obs8;
        fr                = 8'b1011_0010;
        bus.entradas      = fr;
        bus.datos_validos = 1'b1;
        tick();
        bus.datos_validos = 1'b0;
        for (int k = 0; k < 8; k++) begin
            obs = {bus.valido, bus.salida, bus.control,
                   bus.inicio_trama, bus.fin_trama};
            exp = {1'b1, fr[k], 3'(k), k == 0, k == 7};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single k=%0d got=%b exp=%b", k, obs, exp);
            end
            tick();
        end
        obs8 = {bus.datos_listo, bus.valido, bus.salida, bus.control,
                bus.inicio_trama, bus.fin_trama};
        checks++;
        if (obs8 !== 8'b1011_1100) begin
            failures++;
            $display("FAIL single_end got=%b exp=10111100", obs8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa, fb;
        logic [7:0] obs, exp;
        logic       bit_e;
        fa                = 8'hA5;
        fb                = 8'h3C;
        bus.entradas      = fa;
        bus.datos_validos = 1'b1;
        tick();
        bus.entradas = fb;
        for (int k = 0; k < 16; k++) begin
            bit_e = (k < 8) ? fa[k] : fb[k-8];
            obs = {bus.valido, bus.salida, bus.control,
                   bus.inicio_trama, bus.fin_trama, bus.datos_listo};
            exp = {1'b1, bit_e, 3'(k % 8), (k % 8) == 0, (k % 8) == 7,
                   (k % 8) == 7};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL b2b k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k == 8) bus.datos_validos = 1'b0;
            tick();
        end
        obs = {bus.datos_listo, bus.valido, bus.salida, bus.control,
               bus.inicio_trama, bus.fin_trama};
        checks++;
        if (obs !== 8'b1001_1100) begin
            failures++;
            $display("FAIL b2b_end got=%b exp=10011100", obs);
        end
    endtask

    task automatic test_pause();
        logic [6:0] obs, exp;
        logic [2:0] ctl_e, last;
        int         nsym;
        nsym              = 0;
        last              = '0;
        bus.entradas      = 8'hFF;
        bus.datos_validos = 1'b1;
        tick();
        bus.datos_validos = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i <= 4)       ctl_e = 3'(i);
            else if (i <= 8)  ctl_e = 3'd4;
            else if (i <= 11) ctl_e = 3'(i - 4);
            else              ctl_e = 3'd7;
            exp = {!((i >= 5 && i <= 7) || i == 12), 1'b1, ctl_e,
                   i == 0, i == 11};
            obs = {bus.valido, bus.salida, bus.control,
                   bus.inicio_trama, bus.fin_trama};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL pause i=%0d got=%b exp=%b", i, obs, exp);
            end
            if (bus.valido && (nsym == 0 || bus.control != last)) begin
                nsym++;
                last = bus.control;
            end
            bus.pausa = (i >= 4 && i <= 6);
            tick();
        end
        checks++;
        if (nsym !== 8) begin
            failures++;
            $display("FAIL pause_symbols got=%0d exp=8", nsym);
        end
    endtask

    task automatic test_input_change();
        logic [6:0] obs, exp;
        bus.entradas      = 8'h0F;
        bus.datos_validos = 1'b1;
        tick();
        bus.entradas = 8'hF0;
        for (int k = 0; k < 8; k++) begin
            obs = {bus.valido, bus.salida, bus.control,
                   bus.inicio_trama, bus.fin_trama};
            exp = {1'b1, k < 4, 3'(k), k == 0, k == 7};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL in_change k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k == 5) bus.datos_validos = 1'b0;
            tick();
        end
        checks++;
        if (bus.valido !== 1'b0) begin
            failures++;
            $display("FAIL in_change_end valido=%b exp=0", bus.valido);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] fr;
        logic [7:0] obs;
        logic [6:0] o7;
        fr                = 8'h5A;
        bus.entradas      = fr;
        bus.datos_validos = 1'b1;
        tick();
        bus.datos_validos = 1'b0;
        for (int k = 0; k < 4; k++) begin
            o7 = {bus.valido, bus.salida, bus.control,
                  bus.inicio_trama, bus.fin_trama};
            checks++;
            if (o7 !== {1'b1, fr[k], 3'(k), k == 0, 1'b0}) begin
                failures++;
                $display("FAIL rst_mid_pre k=%0d got=%b", k, o7);
            end
            if (k < 3) tick();
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {bus.datos_listo, bus.valido, bus.salida, bus.control,
               bus.inicio_trama, bus.fin_trama};
        checks++;
        if (obs !== 8'b1000_0000) begin
            failures++;
            $display("FAIL rst_mid_async got=%b exp=10000000", obs);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.entradas      = 8'hAA;
        bus.datos_validos = 1'b1;
        tick();
        bus.datos_validos = 1'b0;
        o7 = {bus.valido, bus.salida, bus.control,
              bus.inicio_trama, bus.fin_trama};
        checks++;
        if (o7 !== 7'b1000010) begin
            failures++;
            $display("FAIL rst_mid_restart got=%b exp=1000010", o7);
        end
        tick();
        o7 = {bus.valido, bus.salida, bus.control,
              bus.inicio_trama, bus.fin_trama};
        checks++;
        if (o7 !== 7'b1100100) begin
            failures++;
            $display("FAIL rst_mid_next got=%b exp=1100100", o7);
        end
        repeat (8) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_pause();
        test_input_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
